// File: rtl/nand4_resp_checker.sv
// -----------------------------------------------------------------------------
// nand4_resp_checker
//
// Response checker for the 4-input NAND family. It watches the DUV input
// vector {a,b,c,d} (a = MSB) and the DUV output f. After each change of the
// vector it waits SETTLE_CYC stable cycles, then samples f and compares it
// against the golden ~&vec. It keeps sample, mismatch and coverage statistics
// and flags completion after EXP_SAMPLES samples.
//
// Optional feature: define NAND4_CHK_FAILCAP_EN to keep a record of the first
// mismatching vector. When it is undefined, o_fail_vld and o_fail_vec are 0.
//
// Parameters
//   SETTLE_CYC  : stable cycles required before a sample (1..15)
//   CNT_W       : width of the sample and mismatch counters
//   EXP_SAMPLES : samples that complete a run (1..2^CNT_W-1)
//
// Ports
//   i_clk                : rising-edge clock
//   i_rst_n              : asynchronous active-low reset
//   i_start              : one-cycle pulse, clears statistics and arms
//   i_a, i_b, i_c, i_d   : DUV inputs, vector {a,b,c,d}
//   i_f                  : DUV output
//   o_busy               : armed or settling
//   o_done               : run complete, held until the next i_start
//   o_pass               : valid with o_done; no mismatches and full coverage
//   o_smp_cnt            : samples taken (saturating)
//   o_err_cnt            : mismatches (saturating)
//   o_cov                : bit v set once vector v has been sampled
//   o_fail_vld           : a first-failure record is held
//   o_fail_vec           : vector of the first mismatch
// -----------------------------------------------------------------------------
module nand4_resp_checker #(
  parameter int SETTLE_CYC  = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_SAMPLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_c,
  input  logic             i_d,
  input  logic             i_f,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_smp_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [15:0]      o_cov,
  output logic             o_fail_vld,
  output logic [3:0]       o_fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] EXP_CNT     = CNT_W'(EXP_SAMPLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic nand4(input logic [3:0] v);
    return ~&v;
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec;
  logic [3:0] prev_vec;
  logic [3:0] settle_cnt;
  logic       vec_chg;
  logic       smp_last;

  logic       latch_vec;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       sample;

  logic       vld_p0;
  logic       last_p0;
  logic [3:0] vec_p0;
  logic       mis_p0;

  logic [CNT_W-1:0] err_nxt;
  logic [15:0]      cov_nxt;

  assign vec      = {i_a, i_b, i_c, i_d};
  assign vec_chg  = (vec != prev_vec);
  // Only one sample can be in flight, so the registered count is current here.
  assign smp_last = (sat_inc(o_smp_cnt) == EXP_CNT);
  assign o_busy   = (state == WAIT) || (state == SETTLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_vec = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    sample    = 1'b0;
    if (i_start) begin
      latch_vec = 1'b1;
      cnt_clr   = 1'b1;
      state_nxt = SETTLE;
    end else begin
      case (state)
        IDLE: ;
        WAIT: begin
          if (vec_chg) begin
            latch_vec = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (vec_chg) begin
            // glitch: restart the stability window on the new vector
            latch_vec = 1'b1;
            cnt_clr   = 1'b1;
          end else if (settle_cnt == SETTLE_LAST) begin
            sample    = 1'b1;
            state_nxt = smp_last ? DONE : WAIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_vec   <= 4'd0;
      settle_cnt <= 4'd0;
    end else begin
      if (latch_vec) prev_vec <= vec;
      if (cnt_clr) begin
        settle_cnt <= 4'd0;
      end else if (cnt_inc) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  // ---- stage p0: sampled vector and compare result ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= sample;
      last_p0 <= sample && smp_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (sample) begin
      vec_p0 <= vec;
      mis_p0 <= (i_f != nand4(vec));
    end
  end

  // ---- stage p1: statistics update ----
  assign err_nxt = mis_p0 ? sat_inc(o_err_cnt) : o_err_cnt;
  assign cov_nxt = o_cov | (16'd1 << vec_p0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_smp_cnt <= '0;
      o_err_cnt <= '0;
      o_cov     <= 16'd0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
    end else if (i_start) begin
      // a sample still in p0 is dropped here
      o_smp_cnt <= '0;
      o_err_cnt <= '0;
      o_cov     <= 16'd0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
    end else if (vld_p0) begin
      o_smp_cnt <= sat_inc(o_smp_cnt);
      o_err_cnt <= err_nxt;
      o_cov     <= cov_nxt;
      if (last_p0) begin
        o_done <= 1'b1;
        o_pass <= (err_nxt == '0) && (cov_nxt == 16'hFFFF);
      end
    end
  end

`ifdef NAND4_CHK_FAILCAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fail_vld <= 1'b0;
      o_fail_vec <= 4'd0;
    end else if (i_start) begin
      o_fail_vld <= 1'b0;
      o_fail_vec <= 4'd0;
    end else if (vld_p0 && mis_p0 && !o_fail_vld) begin
      o_fail_vld <= 1'b1;
      o_fail_vec <= vec_p0;
    end
  end
`else
  assign o_fail_vld = 1'b0;
  assign o_fail_vec = 4'd0;
`endif

endmodule

// File: tb/tb_nand4_resp_checker.sv
module tb_nand4_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vec;
  logic       start_a, start_b;
  logic       f_a, f_b;

  logic       busy_a, done_a, pass_a, fvld_a;
  logic [7:0] smp_a, err_a;
  logic [15:0] cov_a;
  logic [3:0] fvec_a;

  logic       busy_b, done_b, pass_b, fvld_b;
  logic [1:0] smp_b, err_b;
  logic [15:0] cov_b;
  logic [3:0] fvec_b;

  always #5 clk = ~clk;

  nand4_resp_checker #(.SETTLE_CYC(2), .CNT_W(8), .EXP_SAMPLES(16)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .i_a(vec[3]), .i_b(vec[2]), .i_c(vec[1]), .i_d(vec[0]), .i_f(f_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_smp_cnt(smp_a), .o_err_cnt(err_a), .o_cov(cov_a),
    .o_fail_vld(fvld_a), .o_fail_vec(fvec_a)
  );

  nand4_resp_checker #(.SETTLE_CYC(3), .CNT_W(2), .EXP_SAMPLES(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .i_a(vec[3]), .i_b(vec[2]), .i_c(vec[1]), .i_d(vec[0]), .i_f(f_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_smp_cnt(smp_b), .o_err_cnt(err_b), .o_cov(cov_b),
    .o_fail_vld(fvld_b), .o_fail_vec(fvec_b)
  );

  typedef struct {
    int          smp;
    int          err;
    logic [15:0] cov;
    logic        done;
    logic        pass;
    logic        fvld;
    logic [3:0]  fvec;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, index 0 = u_dut_a, 1 = u_dut_b
  int          m_smp[2];
  int          m_err[2];
  logic [15:0] m_cov[2];
  logic        m_fvld[2];
  logic [3:0]  m_fvec[2];
  int          exp_n[2]   = '{16, 3};
  int          sat_max[2] = '{255, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic model_clear(input int d);
    m_smp[d]  = 0;
    m_err[d]  = 0;
    m_cov[d]  = 16'd0;
    m_fvld[d] = 1'b0;
    m_fvec[d] = 4'd0;
  endtask

  task automatic model_sample(input int d, input logic [3:0] v, input logic wrong);
    exp_t e;
    if (m_smp[d] < sat_max[d]) m_smp[d]++;
    if (wrong) begin
      if (m_err[d] < sat_max[d]) m_err[d]++;
`ifdef NAND4_CHK_FAILCAP_EN
      if (!m_fvld[d]) begin
        m_fvld[d] = 1'b1;
        m_fvec[d] = v;
      end
`endif
    end
    m_cov[d] = m_cov[d] | (16'd1 << v);
    e.smp  = m_smp[d];
    e.err  = m_err[d];
    e.cov  = m_cov[d];
    e.done = (m_smp[d] == exp_n[d]);
    e.pass = e.done && (m_err[d] == 0) && (m_cov[d] == 16'hFFFF);
    e.fvld = m_fvld[d];
    e.fvec = m_fvec[d];
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [3:0] v, input logic wrong);
    vec = v;
    f_a = (~&v) ^ wrong;
    f_b = (~&v) ^ wrong;
  endtask

  // full 0..15 sweep on u_dut_a, 4-cycle holds, wrong response on masked vectors
  task automatic sweep_a(input logic [15:0] wrong_mask);
    logic [3:0] v;
    set_vec(4'd0, wrong_mask[0]);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    model_clear(0);
    model_sample(0, 4'd0, wrong_mask[0]);
    step(3);
    for (int i = 1; i < 16; i++) begin
      v = 4'(i);
      set_vec(v, wrong_mask[i]);
      model_sample(0, v, wrong_mask[i]);
      step(4);
    end
  endtask

  // scoreboard monitors: a new nonzero sample count marks a stats update
  logic [7:0] prev_smp_a = 8'd0;
  always @(negedge clk) begin
    exp_t e;
    if (smp_a != prev_smp_a && smp_a != 8'd0) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_sample: got smp=%0d, want none", smp_a);
      end else begin
        e = q_a.pop_front();
        check("a_smp", 32'(smp_a), 32'(e.smp));
        check("a_err", 32'(err_a), 32'(e.err));
        check("a_cov", 32'(cov_a), 32'(e.cov));
        check("a_done", 32'(done_a), 32'(e.done));
        check("a_pass", 32'(pass_a), 32'(e.pass));
        check("a_fvld", 32'(fvld_a), 32'(e.fvld));
        check("a_fvec", 32'(fvec_a), 32'(e.fvec));
      end
    end
    prev_smp_a = smp_a;
  end

  logic [1:0] prev_smp_b = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    if (smp_b != prev_smp_b && smp_b != 2'd0) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_sample: got smp=%0d, want none", smp_b);
      end else begin
        e = q_b.pop_front();
        check("b_smp", 32'(smp_b), 32'(e.smp));
        check("b_err", 32'(err_b), 32'(e.err));
        check("b_cov", 32'(cov_b), 32'(e.cov));
        check("b_done", 32'(done_b), 32'(e.done));
        check("b_pass", 32'(pass_b), 32'(e.pass));
        check("b_fvld", 32'(fvld_b), 32'(e.fvld));
        check("b_fvec", 32'(fvec_b), 32'(e.fvec));
      end
    end
    prev_smp_b = smp_b;
  end

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    set_vec(4'd0, 1'b0);
    model_clear(0);
    model_clear(1);
    step(3);

    // reset state
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_smp", 32'(smp_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_cov", 32'(cov_a), 32'd0);
    check("rst_fvld", 32'(fvld_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    step(2);
    check("idle_busy", 32'(busy_a), 32'd0);

    // correct DUV sweep
    sweep_a(16'h0000);
    check("ok_done", 32'(done_a), 32'd1);
    check("ok_pass", 32'(pass_a), 32'd1);
    check("ok_smp", 32'(smp_a), 32'd16);
    check("ok_err", 32'(err_a), 32'd0);
    check("ok_cov", 32'(cov_a), 32'hFFFF);
    check("ok_fvld", 32'(fvld_a), 32'd0);
    check("ok_busy", 32'(busy_a), 32'd0);

    // faulty DUV: wrong on vectors 5 and 9
    sweep_a(16'h0220);
    check("bad_done", 32'(done_a), 32'd1);
    check("bad_err", 32'(err_a), 32'd2);
    check("bad_pass", 32'(pass_a), 32'd0);
    check("bad_cov", 32'(cov_a), 32'hFFFF);
`ifdef NAND4_CHK_FAILCAP_EN
    check("bad_fvld", 32'(fvld_a), 32'd1);
    check("bad_fvec", 32'(fvec_a), 32'h5);
`else
    check("bad_fvld", 32'(fvld_a), 32'd0);
    check("bad_fvec", 32'(fvec_a), 32'h0);
`endif

    // incomplete coverage: vector 15 sampled sixteen times
    set_vec(4'd15, 1'b0);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    model_clear(0);
    model_sample(0, 4'd15, 1'b0);
    check("cov_clr_err", 32'(err_a), 32'd0);
    check("cov_clr_fvld", 32'(fvld_a), 32'd0);
    step(3);
    for (int i = 1; i < 16; i++) begin
      set_vec(4'd14, 1'b0);
      step(1);
      set_vec(4'd15, 1'b0);
      model_sample(0, 4'd15, 1'b0);
      step(4);
    end
    check("cov_done", 32'(done_a), 32'd1);
    check("cov_smp", 32'(smp_a), 32'd16);
    check("cov_err", 32'(err_a), 32'd0);
    check("cov_cov", 32'(cov_a), 32'h8000);
    check("cov_pass", 32'(pass_a), 32'd0);

    // reset during SETTLE after 7 samples
    set_vec(4'd0, 1'b0);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    model_clear(0);
    model_sample(0, 4'd0, 1'b0);
    step(3);
    for (int i = 1; i < 7; i++) begin
      set_vec(4'(i), 1'b0);
      model_sample(0, 4'(i), 1'b0);
      step(4);
    end
    check("mid_smp7", 32'(smp_a), 32'd7);
    set_vec(4'd7, 1'b0);
    step(1);
    check("mid_settle_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy_a), 32'd0);
    check("ar_done", 32'(done_a), 32'd0);
    check("ar_pass", 32'(pass_a), 32'd0);
    check("ar_smp", 32'(smp_a), 32'd0);
    check("ar_err", 32'(err_a), 32'd0);
    check("ar_cov", 32'(cov_a), 32'd0);
    check("ar_fvld", 32'(fvld_a), 32'd0);
    check("ar_fvec", 32'(fvec_a), 32'd0);
    #3 rst_n = 1'b1;
    step(1);
    for (int i = 8; i < 12; i++) begin
      set_vec(4'(i), 1'b0);
      step(3);
    end
    check("post_rst_smp", 32'(smp_a), 32'd0);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    check("post_rst_cov", 32'(cov_a), 32'd0);

    // glitch on u_dut_b (SETTLE_CYC=3): 3 -> 4 for one cycle -> 3
    set_vec(4'd3, 1'b0);
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    model_clear(1);
    set_vec(4'd4, 1'b0);
    step(1);
    set_vec(4'd3, 1'b0);
    model_sample(1, 4'd3, 1'b0);
    step(6);
    check("gl_smp", 32'(smp_b), 32'd1);
    check("gl_cov", 32'(cov_b), 32'h0008);
    check("gl_cov4", 32'(cov_b[4]), 32'd0);
    check("gl_busy", 32'(busy_b), 32'd1);

    // saturation on u_dut_b (CNT_W=2, EXP_SAMPLES=3), DUV always wrong
    set_vec(4'd0, 1'b1);
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    model_clear(1);
    model_sample(1, 4'd0, 1'b1);
    step(4);
    for (int i = 1; i < 3; i++) begin
      set_vec(4'(i), 1'b1);
      model_sample(1, 4'(i), 1'b1);
      step(5);
    end
    check("sat_err", 32'(err_b), 32'd3);
    check("sat_smp", 32'(smp_b), 32'd3);
    check("sat_done", 32'(done_b), 32'd1);
    check("sat_pass", 32'(pass_b), 32'd0);
    set_vec(4'd5, 1'b1);
    step(10);
    check("sat_hold_err", 32'(err_b), 32'd3);
    check("sat_hold_smp", 32'(smp_b), 32'd3);
    check("sat_hold_done", 32'(done_b), 32'd1);

    // back-to-back start: statistics clear on the next edge
    start_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1);
      check("b2b_smp", 32'(smp_b), 32'd0);
      check("b2b_err", 32'(err_b), 32'd0);
      check("b2b_cov", 32'(cov_b), 32'd0);
      check("b2b_done", 32'(done_b), 32'd0);
      check("b2b_pass", 32'(pass_b), 32'd0);
      check("b2b_fvld", 32'(fvld_b), 32'd0);
      check("b2b_busy", 32'(busy_b), 32'd1);
    end
    start_b = 1'b0;
    model_clear(1);
    step(2);

    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
